// File: rtl/sha_double_iterative_core.sv
// rtl/sha_double_iterative_core.sv - folded double-SHA256 engine, ROUNDS rounds per clock
module sha_double_iterative_core #(
  parameter int ROUNDS    = 1,
  parameter int ZERO_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         newblock_i,
  input  logic [255:0] midstate,
  input  logic [31:0]  w0,
  input  logic [31:0]  w1,
  input  logic [31:0]  w2,
  input  logic [31:0]  w3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] doublehash,
  output logic         hit,
  output logic         newblock_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] H1   = 3'd1;
  localparam logic [2:0] ADD1 = 3'd2;
  localparam logic [2:0] H2   = 3'd3;
  localparam logic [2:0] ADD2 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [31:0] HIT_MASK = ~(32'hffff_ffff >> ZERO_BITS);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  logic [2:0]   state_q;
  logic [6:0]   rc_q;
  logic [31:0]  s_q [8];
  logic [31:0]  b_q [8];
  logic [31:0]  w_q [16];
  logic [31:0]  s_rnd [8];
  logic [31:0]  win_nxt [16];
  logic [31:0]  add_sum [8];
  logic [255:0] dh_sum;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // w_q holds W[rc..rc+15]; the expander extends it by up to 16 words so a
  // clock can consume ROUNDS words and still leave a full window behind.
  always_comb begin : round_engine
    logic [31:0] ext [32];
    logic [31:0] rs [8];
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  kidx;
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int i = 16; i < 32; i++)
      ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
    for (int i = 0; i < 8; i++) rs[i] = s_q[i];
    for (int r = 0; r < ROUNDS; r++) begin
      kidx  = rc_q[5:0] + 6'(r);
      t1    = rs[7] + bsig1(rs[4]) + ((rs[4] & rs[5]) ^ (~rs[4] & rs[6])) + K[kidx] + ext[r];
      t2    = bsig0(rs[0]) + ((rs[0] & rs[1]) ^ (rs[0] & rs[2]) ^ (rs[1] & rs[2]));
      rs[7] = rs[6];
      rs[6] = rs[5];
      rs[5] = rs[4];
      rs[4] = rs[3] + t1;
      rs[3] = rs[2];
      rs[2] = rs[1];
      rs[1] = rs[0];
      rs[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+ROUNDS];
    for (int i = 0; i < 8; i++) s_rnd[i] = rs[i];
  end

  always_comb begin
    dh_sum = '0;
    for (int i = 0; i < 8; i++) begin
      add_sum[i] = s_q[i] + b_q[i];
      dh_sum[255-32*i -: 32] = add_sum[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      doublehash <= '0;
      hit        <= 1'b0;
      newblock_o <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      newblock_o <= newblock_i;
      if (newblock_i) begin
        state_q <= IDLE;
        rc_q    <= '0;
      end else begin
        case (state_q)
          IDLE: if (in_valid) begin
            for (int i = 0; i < 8; i++) begin
              s_q[i] <= midstate[255-32*i -: 32];
              b_q[i] <= midstate[255-32*i -: 32];
            end
            w_q[0] <= w0;
            w_q[1] <= w1;
            w_q[2] <= w2;
            w_q[3] <= w3;
            w_q[4] <= 32'h8000_0000;
            for (int i = 5; i < 15; i++) w_q[i] <= '0;
            w_q[15] <= 32'h0000_0280;
            rc_q    <= '0;
            state_q <= H1;
          end
          H1, H2: begin
            for (int i = 0; i < 8; i++) s_q[i] <= s_rnd[i];
            for (int i = 0; i < 16; i++) w_q[i] <= win_nxt[i];
            rc_q <= rc_q + 7'(ROUNDS);
            if (rc_q + 7'(ROUNDS) == 7'd64) state_q <= (state_q == H1) ? ADD1 : ADD2;
          end
          ADD1: begin
            for (int i = 0; i < 8; i++) begin
              w_q[i] <= add_sum[i];
              s_q[i] <= IV[i];
              b_q[i] <= IV[i];
            end
            w_q[8] <= 32'h8000_0000;
            for (int i = 9; i < 15; i++) w_q[i] <= '0;
            w_q[15] <= 32'h0000_0100;
            rc_q    <= '0;
            state_q <= H2;
          end
          ADD2: begin
            doublehash <= dh_sum;
            hit        <= ((dh_sum[31:0] & HIT_MASK) == 32'd0);
            state_q    <= DONE;
          end
          DONE: if (out_ready) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_double_iterative_core.sv
// tb/tb_sha_double_iterative_core.sv - self-checking bench for the folded double-SHA256 core
module tb_sha_double_iterative_core;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV_PACKED = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [255:0] GENESIS_DH = {
    32'h6fe28c0a, 32'hb6f1b372, 32'hc1a6a246, 32'hae63f74f,
    32'h931e8365, 32'he15a089c, 32'h68d61900, 32'h00000000};

  logic clk = 1'b0;
  logic rst;
  logic newblock_i;
  logic [255:0] mid;
  logic [31:0] w0, w1, w2, w3;
  logic in_valid1, in_ready1, out_valid1, out_ready1, hit1, nbo1;
  logic in_valid4, in_ready4, out_valid4, out_ready4, hit4, nbo4;
  logic in_valid16, in_ready16, out_valid16, out_ready16, hit16, nbo16;
  logic [255:0] dh1, dh4, dh16;

  always #5 clk = ~clk;

  sha_double_iterative_core #(.ROUNDS(1), .ZERO_BITS(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .newblock_i(newblock_i),
    .midstate(mid), .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid1),
    .out_ready(out_ready1), .doublehash(dh1), .hit(hit1), .newblock_o(nbo1));

  sha_double_iterative_core #(.ROUNDS(4), .ZERO_BITS(32)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .newblock_i(newblock_i),
    .midstate(mid), .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid4),
    .out_ready(out_ready4), .doublehash(dh4), .hit(hit4), .newblock_o(nbo4));

  sha_double_iterative_core #(.ROUNDS(16), .ZERO_BITS(8)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .newblock_i(newblock_i),
    .midstate(mid), .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid16),
    .out_ready(out_ready16), .doublehash(dh16), .hit(hit16), .newblock_o(nbo16));

  typedef struct {
    logic [255:0] mid;
    logic [31:0]  w0, w1, w2, w3;
    logic [255:0] exp_dh;
    logic         exp_hit;
    int           hold;
  } vec_t;

  typedef struct {
    logic [255:0] dh;
    logic         hit;
  } exp_t;

  vec_t vt [6];
  exp_t sb [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference SHA-256, written straight from the algorithm definition
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hs [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) hs[i] = st[255-32*i -: 32];
    a = hs[0]; b = hs[1]; c = hs[2]; d = hs[3];
    e = hs[4]; f = hs[5]; g = hs[6]; h = hs[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hs[0] + a, hs[1] + b, hs[2] + c, hs[3] + d, hs[4] + e, hs[5] + f, hs[6] + g, hs[7] + h};
  endfunction

  function automatic logic [255:0] dsha(input logic [255:0] m, input logic [31:0] a0,
                                        input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
    logic [255:0] d1;
    d1 = compress(m, {a0, a1, a2, a3, 32'h80000000, 320'd0, 32'h00000280});
    return compress(IV_PACKED, {d1, 32'h80000000, 192'd0, 32'h00000100});
  endfunction

  function automatic logic hit_of(input logic [255:0] dh, input int zb);
    return (dh[31:0] >> (32 - zb)) == 32'd0;
  endfunction

  function automatic logic ov(input int k);
    case (k)
      4: return out_valid4;
      16: return out_valid16;
      default: return out_valid1;
    endcase
  endfunction

  function automatic logic [255:0] get_dh(input int k);
    case (k)
      4: return dh4;
      16: return dh16;
      default: return dh1;
    endcase
  endfunction

  function automatic logic get_hit(input int k);
    case (k)
      4: return hit4;
      16: return hit16;
      default: return hit1;
    endcase
  endfunction

  task automatic set_iv(input int k, input logic v);
    if (k == 4) in_valid4 = v; else if (k == 16) in_valid16 = v; else in_valid1 = v;
  endtask

  task automatic set_or(input int k, input logic v);
    if (k == 4) out_ready4 = v; else if (k == 16) out_ready16 = v; else out_ready1 = v;
  endtask

  task automatic drive_inputs(input vec_t v);
    mid = v.mid; w0 = v.w0; w1 = v.w1; w2 = v.w2; w3 = v.w3;
  endtask

  // Scoreboard consumer for the ROUNDS=1 instance
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && out_valid1 && out_ready1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_result actual=out_valid required=no_pending_job");
      end else begin
        e = sb.pop_front();
        check("sb_doublehash", dh1, e.dh);
        check("sb_hit", {255'd0, hit1}, {255'd0, e.hit});
      end
    end
  end

  // Called just after a posedge; returns just after a posedge with the instance idle.
  task automatic run_job(input vec_t v, input string nm);
    int lat;
    exp_t e;
    drive_inputs(v);
    in_valid1 = 1'b1;
    check({nm, "_in_ready_idle"}, in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    e.dh = v.exp_dh;
    e.hit = v.exp_hit;
    sb.push_back(e);
    lat = 0;
    while (!out_valid1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 130);
    for (int h = 0; h < v.hold; h++) begin
      check({nm, "_hold_out_valid"}, out_valid1, 1);
      check({nm, "_hold_in_ready"}, in_ready1, 0);
      check({nm, "_hold_doublehash"}, dh1, v.exp_dh);
      check({nm, "_hold_hit"}, hit1, v.exp_hit);
      @(posedge clk); #1;
    end
    out_ready1 = 1'b1;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    in_valid1 = 1'b0;
    check({nm, "_out_valid_after_take"}, out_valid1, 0);
    check({nm, "_no_accept_on_take"}, in_ready1, 1);
  endtask

  task automatic run_aux(input int k, input vec_t v, input int exp_lat, input string nm);
    int lat;
    drive_inputs(v);
    set_iv(k, 1'b1);
    @(posedge clk); #1;
    set_iv(k, 1'b0);
    lat = 0;
    while (!ov(k) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_doublehash"}, get_dh(k), v.exp_dh);
    check({nm, "_hit"}, get_hit(k), v.exp_hit);
    set_or(k, 1'b1);
    @(posedge clk); #1;
    set_or(k, 1'b0);
    check({nm, "_out_valid_after_take"}, ov(k), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] gen_mid;
    rst = 1'b0;
    newblock_i = 1'b0;
    mid = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    in_valid1 = 0; in_valid4 = 0; in_valid16 = 0;
    out_ready1 = 0; out_ready4 = 0; out_ready16 = 0;

    gen_mid = compress(IV_PACKED, {32'h01000000, 256'd0,
      32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
      32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa});

    vt[0] = '{gen_mid, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, GENESIS_DH, 1'b1, 20};
    vt[1] = '{gen_mid, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7d, '0, 1'b0, 0};
    vt[2] = '{{256{1'b1}}, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, '0, 1'b0, 1};
    vt[3] = '{256'd0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 2};
    for (int i = 4; i < 6; i++) begin
      for (int j = 0; j < 8; j++) vt[i].mid[255-32*j -: 32] = $urandom;
      vt[i].w0 = $urandom; vt[i].w1 = $urandom; vt[i].w2 = $urandom; vt[i].w3 = $urandom;
      vt[i].hold = 3;
    end
    vt[1].exp_dh = dsha(vt[1].mid, vt[1].w0, vt[1].w1, vt[1].w2, vt[1].w3);
    for (int i = 2; i < 6; i++) begin
      vt[i].exp_dh = dsha(vt[i].mid, vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3);
      vt[i].exp_hit = hit_of(vt[i].exp_dh, 32);
    end

    repeat (2) @(posedge clk); #1;
    check("reset_in_ready", in_ready1, 1);
    check("reset_out_valid", out_valid1, 0);
    check("reset_hit", hit1, 0);
    check("reset_newblock_o", nbo1, 0);
    check("reset_doublehash", dh1, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_aux(4, vt[0], 34, "r4_genesis");
    run_aux(16, vt[0], 10, "r16_genesis");

    for (int i = 0; i < 6; i++) run_job(vt[i], $sformatf("vec%0d", i));

    // newblock in IDLE only pulses newblock_o
    newblock_i = 1'b1;
    @(posedge clk); #1;
    newblock_i = 1'b0;
    check("idle_nb_pulse", nbo1, 1);
    check("idle_nb_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    check("idle_nb_pulse_end", nbo1, 0);

    // abort at rc=37 of H1 with a simultaneous job offer
    drive_inputs(vt[2]);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    check("abort_busy", in_ready1, 0);
    drive_inputs(vt[3]);
    in_valid1 = 1'b1;
    newblock_i = 1'b1;
    @(posedge clk); #1;
    newblock_i = 1'b0;
    in_valid1 = 1'b0;
    check("abort_nb_pulse", nbo1, 1);
    check("abort_job_not_taken", in_ready1, 1);
    check("abort_no_out_valid", out_valid1, 0);
    @(posedge clk); #1;
    check("abort_nb_pulse_end", nbo1, 0);
    run_job(vt[5], "after_abort");

    // asynchronous reset at rc=20 of H2
    drive_inputs(vt[4]);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (85) @(posedge clk);
    #1;
    check("h2_busy", in_ready1, 0);
    rst = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready1, 1);
    check("async_rst_out_valid", out_valid1, 0);
    check("async_rst_hit", hit1, 0);
    check("async_rst_doublehash", dh1, 0);
    check("async_rst_newblock_o", nbo1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(vt[4], "after_reset");

    repeat (2) @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_double_iterative_core.md
Name: sha_double_iterative_core

Overview:
- Parametrised, area-scalable double-SHA256 engine for the mining datapath.
- Takes the first-block midstate and the four second-block header words, and returns SHA256(SHA256(header)) plus a difficulty hit flag.
- Compression is folded: ROUNDS rounds per clock, with the W schedule kept in a rolling 16-word window. One job is in flight at a time.
- Valid/ready handshake on both sides. newblock_i aborts the job in flight.

Parameters:
- ROUNDS, 1, SHA rounds applied per clock. Legal values: 1, 2, 4, 8, 16 (must divide 64).
- ZERO_BITS, 32, leading-zero bits of output word h7 required to assert hit. Range 1..32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  job present.
- in_ready  out  1  engine can accept a job.
- newblock_i  in  1  abort/flush the current job; new chain tip.
- midstate  in  256 (HashState)  state after compressing header bytes 0..63.
- w0  in  32  last 32 bits of the merkle root.
- w1  in  32  timestamp.
- w2  in  32  difficulty target (bits).
- w3  in  32  nonce.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- doublehash  out  256 (HashState)  final double hash.
- hit  out  1  top ZERO_BITS of doublehash h7 are zero.
- newblock_o  out  1  one-cycle pulse, registered one cycle after newblock_i is sampled high.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, hit=0, newblock_o=0, doublehash=0, round counter=0.
- Accept: a job is taken on a clk edge with in_valid && in_ready.
  - Latch midstate into state register S and into base register B.
  - Load the W window: w0..w3, 0x80000000, 10 words of 0x00000000, 0x00000280.
- FSM:
  - IDLE: in_ready=1. Accept -> H1.
  - H1: apply ROUNDS rounds per clock using K[rc..rc+ROUNDS-1]; rc += ROUNDS. The W window shifts by ROUNDS words per clock; the expander produces new words for t>=16. When rc reaches 64 -> ADD1.
  - ADD1 (1 clock): digest1 = S + B, word-wise mod 2^32.
    - Load the W window: digest1 h0..h7, 0x80000000, 6 words of 0, 0x00000100.
    - Load S and B with the initial hash value (H0=0x6a09e667 ... H7=0x5be0cd19). rc=0. -> H2.
  - H2: same round engine. At rc=64 -> ADD2.
  - ADD2 (1 clock): doublehash = S + B. hit = (doublehash.h7[31:32-ZERO_BITS]==0). -> DONE.
  - DONE: out_valid=1; doublehash and hit held stable. On out_ready -> IDLE.
- in_ready is 1 only in IDLE. No job is accepted in the same cycle a result is consumed; the earliest accept is the next cycle.
- Latency, from the accept edge to out_valid=1: 2*(64/ROUNDS)+2 cycles. ROUNDS=1 gives 130 cycles; ROUNDS=4 gives 34 cycles.
- newblock_i=1 sampled on any edge:
  - FSM goes to IDLE and any DONE result is discarded (out_valid drops the next cycle).
  - newblock_o pulses the next cycle.
  - newblock_i has priority over a simultaneous accept: the job is not taken.
  - newblock_i in IDLE only pulses newblock_o.
- A result in DONE with out_ready=0 is held indefinitely; out_valid never drops without a handshake, newblock_i or reset.
- All adds are 32-bit wrap-around. No carries cross words.
- Reset asserted mid-job clears everything immediately; no partial output is produced.

Test Plan:
- Genesis header, ROUNDS=1, ZERO_BITS=32:
  - midstate from the golden model; w0..w3 = header words 16..19 with nonce word=0x1dac2b7c.
  - Required: out_valid exactly 130 cycles after accept.
  - doublehash = 6fe28c0a b6f1b372 c1a6a246 ae63f74f 931e8365 e15a089c 68d61900 00000000; hit=1.
- Same job at ROUNDS=4 and ROUNDS=16 -> identical doublehash; out_valid at 34 and 10 cycles respectively.
- Genesis with nonce word=0x1dac2b7d -> doublehash matches the golden model; hit=0 (h7 nonzero).
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> doublehash and hit stable throughout, in_ready=0. Raise out_ready -> IDLE, with in_ready=1 the next cycle.
- newblock_i pulsed at rc=37 of H1, with in_valid=1 in the same cycle:
  - job dropped, newblock_o pulse one cycle later, no out_valid.
  - the next job, accepted 2 cycles later, completes correctly.
- Assert rst low at rc=20 of H2 -> outputs go to reset values asynchronously. After release, a fresh job matches the golden model.
